// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Supervises a PLL's reset/lock handshake. It pulses the PLL RESET input,
// waits for the asynchronous lock indication, and requires lock to stay
// stable for a programmable time before it releases the system reset. If lock
// does not arrive within a timeout, the PLL is retried. If lock is lost after
// qualification, the system goes back into reset and the PLL is retried.
// Timeouts and lock losses are counted (saturating) for debug readout.
//
// Ports:
//   clk         free-running board clock (same clock as the PLL clkin)
//   reset       synchronous, active-high reset
//   lock_async  PLL lock output, asynchronous to clk
//   pll_reset   drives the PLL RESET input
//   sys_reset   active-high system reset, synchronous to clk
//   clk_good    high only while the PLL is locked and qualified
//   retry_cnt   saturating count of lock timeouts
//   lost_cnt    saturating count of lock losses after qualification
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 100000,
  parameter int unsigned TMR_W            = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lock_async,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       clk_good,
  output logic [7:0] retry_cnt,
  output logic [7:0] lost_cnt
);

  typedef enum logic [1:0] {
    S_RST    = 2'd0,
    S_WAIT   = 2'd1,
    S_STABLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  // Terminal timer values: a state with terminal value N-1 lasts N cycles.
  localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] timer;
  logic             lock_meta;
  logic             lock_s;
  logic             retry_inc;
  logic             lost_inc;

  // Transition logic. Lock has priority over the timeout in S_WAIT, and a
  // lock drop has priority over qualification completion in S_STABLE.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt = state;
    retry_inc = 1'b0;
    lost_inc  = 1'b0;
    unique case (state)
      S_RST: begin
        if (timer == RST_LAST) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (lock_s) begin
          state_nxt = S_STABLE;
        end else if (timer == TIMEOUT_LAST) begin
          state_nxt = S_RST;
          retry_inc = 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s)                   state_nxt = S_WAIT;
        else if (timer == STABLE_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!lock_s) begin
          state_nxt = S_RST;
          lost_inc  = 1'b1;
        end
      end
      default: state_nxt = S_RST;
    endcase
  end

  // NOTE: reset is synchronous here, sampled only on the clock edge, so the
  // reset branch lives inside the clocked block with no reset in the
  // sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      state     <= S_RST;
      timer     <= '0;
      retry_cnt <= 8'd0;
      lost_cnt  <= 8'd0;
      pll_reset <= 1'b1;
      sys_reset <= 1'b1;
      clk_good  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values (this is what makes the two-flop chain a
      // synchronizer rather than a wire).
      lock_meta <= lock_async;
      lock_s    <= lock_meta;
      state     <= state_nxt;
      // Timer restarts on every state entry, including S_WAIT re-entry from
      // S_STABLE after a lock glitch.
      timer     <= (state_nxt != state) ? '0 : timer + TMR_W'(1);
      if (retry_inc && retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
      if (lost_inc  && lost_cnt  != 8'hFF) lost_cnt  <= lost_cnt + 8'd1;
      // Outputs are registered alongside the state, so they always equal the
      // decode of the state register.
      pll_reset <= (state_nxt == S_RST);
      sys_reset <= (state_nxt != S_RUN);
      clk_good  <= (state_nxt == S_RUN);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Directed bench for pll_lock_supervisor with RST_PULSE_CYC=4,
// LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32. Expected output vectors are pushed
// to a scoreboard queue before the clock edge that should produce them and
// popped/compared one time unit after that edge.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam int RP  = 4;
  localparam int LS  = 8;
  localparam int LT  = 32;
  localparam int PER = RP + LT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lock_async = 1'b0;
  logic       pll_reset;
  logic       sys_reset;
  logic       clk_good;
  logic [7:0] retry_cnt;
  logic [7:0] lost_cnt;

  pll_lock_supervisor #(
    .RST_PULSE_CYC   (RP),
    .LOCK_STABLE_CYC (LS),
    .LOCK_TIMEOUT_CYC(LT),
    .TMR_W           (20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .lock_async(lock_async),
    .pll_reset (pll_reset),
    .sys_reset (sys_reset),
    .clk_good  (clk_good),
    .retry_cnt (retry_cnt),
    .lost_cnt  (lost_cnt)
  );

  always #5 clk = ~clk;

  // Output vector layout: {pll_reset, sys_reset, clk_good, retry_cnt, lost_cnt}
  typedef struct {
    string       tag;
    logic [18:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Watchdog: the directed sequence is finite, this only guards a stuck sim.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input bit pll, input bit sys, input bit good,
                      input logic [7:0] retry, input logic [7:0] lost);
    exp_t e;
    e.tag = tag;
    e.exp = {pll, sys, good, retry, lost};
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [18:0] obs;
    obs = {pll_reset, sys_reset, clk_good, retry_cnt, lost_cnt};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty: observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s: observed pll=%b sys=%b good=%b retry=%0d lost=%0d, expected pll=%b sys=%b good=%b retry=%0d lost=%0d",
               e.tag, obs[18], obs[17], obs[16], obs[15:8], obs[7:0],
               e.exp[18], e.exp[17], e.exp[16], e.exp[15:8], e.exp[7:0]);
      end
    end
  endtask

  // Push an expectation, advance n edges, compare after the last one.
  task automatic exp_after(input int n, input string tag, input bit pll, input bit sys,
                           input bit good, input logic [7:0] retry, input logic [7:0] lost);
    push(tag, pll, sys, good, retry, lost);
    tick(n);
    check();
  endtask

  // One reset edge; afterwards the bench is at "cycle 0" with reset released.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    exp_after(1, tag, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
    reset = 1'b0;
  endtask

  initial begin
    // ---------------- normal bring-up ----------------
    lock_async = 1'b0;
    do_reset("reset_state");
    exp_after(3, "bringup_pll_c3", 1, 1, 0, 0, 0);
    exp_after(1, "bringup_pll_c4", 0, 1, 0, 0, 0);
    tick(6);                                   // cycle 10
    lock_async = 1'b1;                         // next edge is E
    exp_after(10, "bringup_e9", 0, 1, 0, 0, 0);
    exp_after(1, "bringup_e10", 0, 0, 1, 0, 0);

    // ---------------- lock loss in S_RUN ----------------
    lock_async = 1'b0;                         // next edge is F
    exp_after(2, "loss_f1", 0, 0, 1, 0, 0);
    exp_after(1, "loss_f2", 1, 1, 0, 0, 1);
    tick(10);
    lock_async = 1'b1;
    exp_after(10, "requal_e9", 0, 1, 0, 0, 1);
    exp_after(1, "requal_e10", 0, 0, 1, 0, 1);

    // ---------------- glitch while qualifying ----------------
    lock_async = 1'b0;
    do_reset("glitch_reset");
    tick(10);
    lock_async = 1'b1;                         // E
    tick(7);                                   // after E+6: 5th S_STABLE cycle
    lock_async = 1'b0;
    tick(1);                                   // E+7 samples low
    lock_async = 1'b1;
    tick(1);                                   // E+8 re-samples high (E')
    exp_after(2, "glitch_no_early_run", 0, 1, 0, 0, 0);
    exp_after(7, "glitch_e9", 0, 1, 0, 0, 0);
    exp_after(1, "glitch_e10", 0, 0, 1, 0, 0);

    // ---------------- lock arrives on the timeout cycle ----------------
    lock_async = 1'b0;
    do_reset("race_reset");
    tick(33);                                  // cycle 33
    lock_async = 1'b1;                         // E = edge 34, lock_s seen at edge 36
    exp_after(3, "race_no_retry_c36", 0, 1, 0, 0, 0);
    exp_after(7, "race_c43", 0, 1, 0, 0, 0);
    exp_after(1, "race_run_c44", 0, 0, 1, 0, 0);

    // ---------------- never lock ----------------
    lock_async = 1'b0;
    do_reset("never_reset");
    for (int c = 1; c <= 200; c++) begin
      exp_after(1, $sformatf("never_lock_c%0d", c), ((c % PER) < RP), 1'b1, 1'b0,
                8'(c / PER), 8'd0);
    end

    // ---------------- retry_cnt saturation ----------------
    do_reset("sat_reset");
    for (int c = 1; c <= 300 * PER; c++) begin
      if (c == 254 * PER || c == 255 * PER || c == 256 * PER || c == 300 * PER) begin
        exp_after(1, $sformatf("sat_c%0d", c), 1'b1, 1'b1, 1'b0,
                  (c / PER > 255) ? 8'd255 : 8'(c / PER), 8'd0);
      end else begin
        tick(1);
      end
    end

    // ---------------- reset mid-operation ----------------
    do_reset("midop_reset0");
    tick(10);
    lock_async = 1'b1;
    exp_after(11, "midop_run", 0, 0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      lock_async = 1'b0;
      exp_after(3, $sformatf("midop_loss%0d", i), 1, 1, 0, 0, 8'(i));
      tick(8);
      lock_async = 1'b1;
      exp_after(11, $sformatf("midop_requal%0d", i), 0, 0, 1, 0, 8'(i));
    end
    do_reset("midop_reset");                   // lock stays high
    exp_after(12, "midop_c12", 0, 1, 0, 0, 0);
    exp_after(1, "midop_c13", 0, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
